// File: rtl/riscuinho_pkg.sv
// Shared definitions for the RISCuinho control path: sequencer states, RV32I
// major opcodes, writeback/next-PC select encodings and opcode classes.
package riscuinho_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } seq_state_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [1:0] RD_SRC_ALU  = 2'b00;
    localparam logic [1:0] RD_SRC_LOAD = 2'b01;
    localparam logic [1:0] RD_SRC_PC4  = 2'b10;
    localparam logic [1:0] RD_SRC_IMM  = 2'b11;

    localparam logic [1:0] PC_SRC_PC4    = 2'b00;
    localparam logic [1:0] PC_SRC_PC_IMM = 2'b01;
    localparam logic [1:0] PC_SRC_RS1    = 2'b10;

    typedef enum logic [3:0] {
        CLS_OP,
        CLS_OP_IMM,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE,
        CLS_FENCE,
        CLS_SYSTEM,
        CLS_CSR,
        CLS_ILLEGAL
    } opc_class_e;

    function automatic logic [1:0] wb_source(input opc_class_e cls);
        case (cls)
            CLS_LOAD:          return RD_SRC_LOAD;
            CLS_JAL, CLS_JALR: return RD_SRC_PC4;
            CLS_LUI, CLS_CSR:  return RD_SRC_IMM;
            default:           return RD_SRC_ALU;
        endcase
    endfunction

    function automatic logic [1:0] wb_pc_source(input opc_class_e cls);
        case (cls)
            CLS_JAL:  return PC_SRC_PC_IMM;
            CLS_JALR: return PC_SRC_RS1;
            default:  return PC_SRC_PC4;
        endcase
    endfunction

endpackage

// File: rtl/riscuinho_control_seq_if.sv
// Instruction/data memory request-ready handshake between the sequencer
// (master) and the memory side (slave).
interface riscuinho_control_seq_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/riscuinho_opcode_class.sv
// Combinational RV32I opcode classifier; shared by the control sequencer and
// the instruction-table trace monitor.
module riscuinho_opcode_class
    import riscuinho_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output opc_class_e cls,
    output logic       legal
);

    always_comb begin
        cls   = CLS_ILLEGAL;
        legal = 1'b1;
        case (opcode)
            OPC_OP:       cls = CLS_OP;
            OPC_OP_IMM:   cls = CLS_OP_IMM;
            OPC_LUI:      cls = CLS_LUI;
            OPC_AUIPC:    cls = CLS_AUIPC;
            OPC_JAL:      cls = CLS_JAL;
            OPC_JALR:     cls = CLS_JALR;
            OPC_BRANCH:   cls = CLS_BRANCH;
            OPC_LOAD:     cls = CLS_LOAD;
            OPC_STORE:    cls = CLS_STORE;
            OPC_MISC_MEM: cls = CLS_FENCE;
            // funct3 == 0 is ECALL/EBREAK; every other SYSTEM encoding is a CSR op
            OPC_SYSTEM:   cls = (funct3 == 3'd0) ? CLS_SYSTEM : CLS_CSR;
            default: begin
                cls   = CLS_ILLEGAL;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/riscuinho_control_seq.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer for RISCuinho.
// Define RISCUINHO_TRACE_EN to expose state/retire and the instret counter.
module riscuinho_control_seq
    import riscuinho_pkg::*;
#(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [6:0]                     opcode,
    input  logic [2:0]                     funct3,
    input  logic [4:0]                     rd_sel,
    input  logic                           branch_taken,
    riscuinho_control_seq_if.master        bus,
    output logic                           ir_we,
    output logic                           rf_we,
    output logic [1:0]                     rd_data_sel,
    output logic                           pc_we,
    output logic [1:0]                     pc_sel,
    output logic [2:0]                     state,
    output logic                           halted,
    output logic                           illegal,
    output logic                           retire
`ifdef RISCUINHO_TRACE_EN
    ,
    output logic [31:0]                    instret
`endif
);

    seq_state_e state_q;
    seq_state_e state_d;
    opc_class_e cls;
    logic       legal;
    logic       imem_req_c;
    logic       dmem_req_c;
    logic       dmem_we_c;
    logic       set_halt;
    logic       set_illegal;

    riscuinho_opcode_class u_opcode_class (
        .opcode (opcode),
        .funct3 (funct3),
        .cls    (cls),
        .legal  (legal)
    );

    always_comb begin
        state_d     = state_q;
        imem_req_c  = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        ir_we       = 1'b0;
        rf_we       = 1'b0;
        rd_data_sel = RD_SRC_ALU;
        pc_we       = 1'b0;
        pc_sel      = PC_SRC_PC4;
        set_halt    = 1'b0;
        set_illegal = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!legal) begin
                    set_illegal = 1'b1;
                    state_d     = ST_HALT;
                end else if (cls == CLS_SYSTEM) begin
                    set_halt = 1'b1;
                    state_d  = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cls == CLS_BRANCH) begin
                    pc_we   = 1'b1;
                    pc_sel  = branch_taken ? PC_SRC_PC_IMM : PC_SRC_PC4;
                    state_d = ST_FETCH;
                end else if (cls == CLS_LOAD || cls == CLS_STORE) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (cls == CLS_STORE);
                if (bus.dmem_ready) begin
                    if (cls == CLS_STORE) begin
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we       = (rd_sel != '0);
                rd_data_sel = wb_source(cls);
                pc_we       = 1'b1;
                pc_sel      = wb_pc_source(cls);
                state_d     = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // reset wins over every strobe so abandoned requests drop immediately
        if (rst) begin
            imem_req_c  = 1'b0;
            dmem_req_c  = 1'b0;
            dmem_we_c   = 1'b0;
            ir_we       = 1'b0;
            rf_we       = 1'b0;
            rd_data_sel = RD_SRC_ALU;
            pc_we       = 1'b0;
            pc_sel      = PC_SRC_PC4;
            set_halt    = 1'b0;
            set_illegal = 1'b0;
        end
    end

    assign bus.imem_req = imem_req_c;
    assign bus.dmem_req = dmem_req_c;
    assign bus.dmem_we  = dmem_we_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= seq_state_e'(RESET_STATE);
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            if (set_halt)    halted  <= 1'b1;
            if (set_illegal) illegal <= 1'b1;
        end
    end

`ifdef RISCUINHO_TRACE_EN
    // Retirement coincides with pc_we, except ECALL/EBREAK which retire in DECODE.
    assign retire = pc_we | set_halt;
    assign state  = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + 32'd1;
        end
    end
`else
    assign retire = 1'b0;
    assign state  = '0;
`endif

endmodule

// File: doc/riscuinho_control_seq.md
# riscuinho_control_seq

Multicycle control sequencer for the RISCuinho core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the enable and select strobes for the PC, IR, register file and data memory. It also owns the `rd_data_sel` writeback mux select consumed by the register-file write path, and exposes its state so the simulation instruction-table monitor can tag each trace line.

## Interface
Parameters:
- `RESET_STATE`, default `3'd0` (FETCH): state entered on reset.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `opcode`  in  7  `instr[6:0]` from the IR.
- `funct3`  in  3  `instr[14:12]` from the IR.
- `rd_sel`  in  5  destination register index.
- `branch_taken`  in  1  ALU compare result, valid in EXEC.
- `imem_ready`  in  1  instruction memory data valid.
- `dmem_ready`  in  1  data memory access complete.
- `imem_req`  out  1  instruction fetch request.
- `ir_we`  out  1  IR load strobe.
- `dmem_req`  out  1  data memory request.
- `dmem_we`  out  1  data memory write (store).
- `rf_we`  out  1  register-file write enable.
- `rd_data_sel`  out  2  writeback source: 00 ALU, 01 load data, 10 PC+4, 11 imm_csr.
- `pc_we`  out  1  PC update strobe.
- `pc_sel`  out  2  next PC: 00 PC+4, 01 PC+imm (branch/JAL), 10 rs1+imm (JALR).
- `state`  out  3  current state, for trace.
- `halted`  out  1  sticky; ECALL/EBREAK retired.
- `illegal`  out  1  sticky; unknown opcode decoded.
- `retire`  out  1  one-cycle pulse per completed instruction.
- `instret`  out  32  retired-instruction count; present only with the trace macro (see Configuration).

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- **FETCH**
  - `imem_req`=1 and held until `imem_ready`.
  - On `imem_ready`: `ir_we`=1 in the same cycle, then go to DECODE.
- **DECODE** (1 cycle): classify `opcode`.
  - Unknown opcode: set `illegal`, go to HALT.
  - SYSTEM with `funct3`=0 (ECALL/EBREAK): set `halted`, `retire`=1, go to HALT.
  - Anything else: go to EXEC.
- **EXEC** (1 cycle)
  - BRANCH: `pc_we`=1, `pc_sel`=01 if `branch_taken` else 00, `retire`=1, go to FETCH.
  - LOAD or STORE: go to MEM.
  - All other classes: go to WB.
- **MEM**
  - `dmem_req`=1 held until `dmem_ready`; `dmem_we`=1 for STORE.
  - STORE on `dmem_ready`: `pc_we`=1, `pc_sel`=00, `retire`=1, go to FETCH.
  - LOAD on `dmem_ready`: go to WB.
- **WB** (1 cycle)
  - `rf_we`=1 unless `rd_sel`==0; `pc_we`=1; `retire`=1; go to FETCH.
  - `rd_data_sel` by class: OP/OP-IMM/AUIPC=00, LOAD=01, JAL/JALR=10, LUI/CSR=11.
  - `pc_sel` by class: JAL=01, JALR=10, others=00.
- **HALT**
  - Absorbing; only `rst` leaves it.
  - All strobes held at 0.
- Strobes are combinational from `state`, the decode inputs and the ready inputs. Every strobe not named for a state is 0 in that state.

## Timing
- Reset:
  - `rst` high at an edge: `state`=RESET_STATE, `halted`=0, `illegal`=0, `instret`=0.
  - While `rst` is high, all strobe outputs are forced to 0.
- Reset mid-operation: any pending imem/dmem request is abandoned; `imem_req` is first reasserted in the first cycle after `rst` falls.
- Latency with zero-wait memories (ready=1 on the first request cycle):
  - OP/LUI/JAL: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Each memory wait cycle adds 1 cycle.
- `req` stays stable and high until `ready`. A `ready` arriving while `req` is low is ignored.
- `retire` and `pc_we` assert in the same final cycle; at most one `retire` per instruction.

## Configuration
- `RISCUINHO_TRACE_EN` defined:
  - 32-bit `instret` increments on each `retire` and wraps from 0xFFFFFFFF to 0.
  - `state` and `retire` are driven as specified.
- Not defined:
  - `instret` port and counter are absent.
  - `state` is tied to 0 and `retire` is tied to 0.
  - Sequencing is unchanged.

## Structure
- `riscuinho_pkg` holds:
  - state encodings;
  - RV32I opcode constants;
  - `rd_data_sel` and `pc_sel` encodings;
  - opcode class enum.
- One sub-module, `riscuinho_opcode_class`: combinational `opcode`/`funct3` → class + legal flag. It is shared with the instruction-table monitor.

## Test plan
- ADDI x5 with `imem_ready`=1 always → `rf_we`=1, `rd_data_sel`=00, `retire` at cycle 4 after reset release; `instret`=1.
- LW x3 with `dmem_ready` delayed 2 cycles → `dmem_req` high 3 cycles, `dmem_we`=0, WB `rd_data_sel`=01; 7 cycles total.
- BEQ taken vs. not taken → `pc_sel`=01 vs. 00 at cycle 3, `rf_we` never asserted.
- ADD x0 (`rd_sel`=0) → `rf_we`=0 in WB, `pc_we`=1, `retire`=1.
- Opcode 0x7F → `illegal`=1 after DECODE, all strobes 0 thereafter; `rst` pulse returns to FETCH with `illegal`=0.
- `rst` asserted during a MEM wait → next cycle `dmem_req`=0, `state`=0; `instret` 0xFFFFFFFF + `retire` → wraps to 0.
